// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// PRId value and SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] PRID_VAL = 32'h0000_0714;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_BD    = 31;

endpackage

// File: rtl/cp0_req_arb.sv
// CP0 request arbiter: decides whether an interrupt or exception
// is taken this cycle and which ExcCode gets recorded.
module cp0_req_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code,
    output logic       int_pend,
    output logic       exc_pend,
    output logic       int_req,
    output logic [4:0] sel_code
);

    // interrupts win over synchronous exceptions; EXL blocks both
    always_comb begin
        int_pend = (|(hw_int & im)) & ie & ~exl;
        exc_pend = (exc_code != EXC_INT) & ~exl;
        int_req  = int_pend | exc_pend;
        sel_code = int_pend ? EXC_INT : exc_code;
    end

endmodule

// File: rtl/cp0.sv
// CP0 coprocessor: SR, Cause, EPC, PRId with exception entry.
// Define CP0_BD_EN to enable branch-delay capture and EPC-4.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        we,
    input  logic [31:0] PC,
    input  logic        bd,
    input  logic [6:2]  ExcCode,
    input  logic [7:2]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd_r;
    logic [5:0]  ip;
    logic [4:0]  exc_r;
    logic [31:0] epc_r;

    logic        int_pend;
    logic        exc_pend;
    logic [4:0]  sel_code;
    logic [31:0] pc_al;
    logic [31:0] epc_nxt;
    logic        bd_nxt;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    cp0_req_arb u_arb (
        .hw_int   (HWInt),
        .im       (im),
        .ie       (ie),
        .exl      (exl),
        .exc_code (ExcCode),
        .int_pend (int_pend),
        .exc_pend (exc_pend),
        .int_req  (IntReq),
        .sel_code (sel_code)
    );

    assign pc_al = {PC[31:2], 2'b00};

`ifdef CP0_BD_EN
    logic [1:0] unused_pc;
    assign unused_pc = PC[1:0];

    // delay-slot faults restart at the branch itself
    always_comb begin
        bd_nxt  = bd;
        epc_nxt = bd ? pc_al - 32'd4 : pc_al;
    end
`else
    logic [2:0] unused_in;
    assign unused_in = {PC[1:0], bd};

    // without delay-slot tracking the faulting PC is saved as-is
    always_comb begin
        bd_nxt  = 1'b0;
        epc_nxt = pc_al;
    end
`endif

    // register update: reset, then exception entry, then mtc0/eret
    always_ff @(posedge clk) begin
        if (reset) begin
            im    <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            bd_r  <= 1'b0;
            ip    <= '0;
            exc_r <= '0;
            epc_r <= '0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl   <= 1'b1;
                bd_r  <= bd_nxt;
                exc_r <= sel_code;
                epc_r <= epc_nxt;
            end else begin
                if (we && A2 == REG_SR) begin
                    im  <= DIn[SR_IM_HI:SR_IM_LO];
                    exl <= DIn[SR_EXL];
                    ie  <= DIn[SR_IE];
                end
                if (we && A2 == REG_EPC) begin
                    epc_r <= {DIn[31:2], 2'b00};
                end
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    assign sr_val    = {16'b0, im, 8'b0, exl, ie};
    assign cause_val = {bd_r, 15'b0, ip, 3'b0, exc_r, 2'b00};
    assign EPC       = epc_r;

    // mfc0 read mux; unmapped numbers read zero
    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc_r;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = '0;
        endcase
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 A1  input  5  mfc0 read register number.
REQ-004 A2  input  5  mtc0 write register number.
REQ-005 DIn  input  32  mtc0 write data.
REQ-006 we  input  1  mtc0 write enable.
REQ-007 PC  input  32  PC of the instruction currently at the exception point.
REQ-008 bd  input  1  that instruction sits in a branch delay slot.
REQ-009 ExcCode  input  [6:2]  pipeline exception code; 0 means no exception (Ov=12, AdEL=4, AdES=5, RI=10).
REQ-010 HWInt  input  [7:2]  six level-sensitive hardware interrupt lines.
REQ-011 EXLClr  input  1  eret retiring; clear EXL.
REQ-012 IntReq  output  1  take exception or interrupt this cycle; pipeline flushes and PC goes to the handler.
REQ-013 EPC  output  32  current EPC register value.
REQ-014 DOut  output  32  combinational read of the register selected by A1.

Function
REQ-015 Registers: SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC(14); PRId(15) constant 32'h0000_0714.
REQ-016 Other bits of SR and Cause read as 0; an A1 value outside 12-15 returns 0.
REQ-017 IntPend = |(HWInt & IM) & IE & ~EXL.
REQ-018 ExcPend = (ExcCode != 0) & ~EXL.
REQ-019 IntReq = IntPend | ExcPend; purely combinational, same cycle as its inputs.
REQ-020 Priority: interrupt over exception; Cause.ExcCode <= 0 when IntPend, else the ExcCode input.
REQ-021 On IntReq at the clock edge: EXL <= 1; BD <= bd; EPC <= bd ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
REQ-022 Cause.IP <= HWInt every cycle, regardless of EXL, IE or IntReq.
REQ-023 mtc0 (we=1, no IntReq): A2=12 writes IM/EXL/IE from DIn; A2=14 writes {DIn[31:2],2'b00}; writes to 13, 15 or other addresses are ignored.
REQ-024 Same-cycle collisions: IntReq beats mtc0 (write dropped); IntReq beats EXLClr (EXL ends at 1).
REQ-025 EXLClr without IntReq: EXL <= 0 at the edge; the mtc0 SR write applies first, then EXLClr overrides EXL.
REQ-026 While EXL=1, no new exception or interrupt is taken, so nesting is impossible.
REQ-027 Read-after-write: DOut shows the old value in the write cycle and the new value from the next cycle.
REQ-028 The EPC output is the registered EPC, visible to eret one cycle after the exception edge.

Reset
REQ-029 Reset clears SR, Cause and EPC to 0, so IntReq=0 and DOut(A1=12/13/14)=0 in the following cycle.
REQ-030 Reset has priority over IntReq, mtc0 and EXLClr in the same cycle.
REQ-031 PRId is unaffected by reset.

Configuration
REQ-032 CP0_BD_EN defined: BD capture and EPC-4 adjustment per REQ-021.
REQ-033 CP0_BD_EN undefined: bd input ignored, Cause.BD reads 0, EPC <= {PC[31:2],2'b00} always.

Structure
REQ-034 Shared package holds CP0 register numbers (12-15), ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), the PRId value and the SR/Cause bit positions.
REQ-035 One sub-module, cp0_req_arb: computes IntPend, ExcPend, IntReq and the selected ExcCode combinationally; all state stays in cp0.

Verification
REQ-036 mtc0 SR=32'h0000_0401, HWInt=6'b000001 -> IntReq=1 same cycle; next cycle SR=32'h0000_0403, Cause.ExcCode=0, IP=6'b000001.
REQ-037 ExcCode=12, PC=32'h0000_3010, bd=0, EXL=0 -> IntReq=1; next cycle EPC=32'h0000_3010, Cause=32'h0000_0030.
REQ-038 ExcCode=4, PC=32'h0000_3024, bd=1 -> EPC=32'h0000_3020, Cause[31]=1 with CP0_BD_EN; EPC=32'h0000_3024, Cause[31]=0 without it.
REQ-039 EXL=1, ExcCode=5, HWInt enabled -> IntReq=0 and no register change; then EXLClr=1 -> EXL=0 and the pending interrupt asserts IntReq the next cycle.
REQ-040 we=1, A2=14, DIn=32'h0000_4183 with ExcCode=10 same cycle -> EPC = exception PC, not 32'h0000_4180; repeat without exception -> EPC=32'h0000_4180.
REQ-041 Reset asserted mid-handler (EXL=1) -> SR=Cause=EPC=0 next cycle, DOut(A1=15)=32'h0000_0714.
